dmem_responder: RTL

Data-memory responder for the RISC-V core's load/store port, and the memory end of the CPU's R_en/W_en/ram_addr/Wr_mem_data/Rd_mem_data interface. It accepts one request at a time and inserts a configurable number of wait states. It performs byte/half/word stores with lane steering, and returns sign- or zero-extended load data with a one-cycle ready pulse. It replaces the zero-latency data_memory array once the core stalls on mem_ready.

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, lane widths.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_WX = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } dmem_state_e;

    localparam int unsigned LANE_SEL_W = 2;
    localparam int unsigned NUM_LANES  = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data memory (slave).
// Optional mem_err signal exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_responder_if;
    logic        R_en;
    logic        W_en;
    logic [31:0] ram_addr;
    logic [31:0] Wr_mem_data;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] Rd_mem_data;
    logic        mem_ready;
    logic        mem_busy;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mem_err;

    modport master (
        output R_en, W_en, ram_addr, Wr_mem_data, mem_size, mem_unsigned,
        input  Rd_mem_data, mem_ready, mem_busy, mem_err
    );
    modport slave (
        input  R_en, W_en, ram_addr, Wr_mem_data, mem_size, mem_unsigned,
        output Rd_mem_data, mem_ready, mem_busy, mem_err
    );
`else
    modport master (
        output R_en, W_en, ram_addr, Wr_mem_data, mem_size, mem_unsigned,
        input  Rd_mem_data, mem_ready, mem_busy
    );
    modport slave (
        input  R_en, W_en, ram_addr, Wr_mem_data, mem_size, mem_unsigned,
        output Rd_mem_data, mem_ready, mem_busy
    );
`endif
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated data and load extract/extend.
// Misalignment detection is built only when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]            size,
    input  logic [LANE_SEL_W-1:0] addr_lo,
    input  logic [31:0]           wdata,
    input  logic [31:0]           rword,
    input  logic                  is_unsigned,
    output logic [NUM_LANES-1:0]  be,
    output logic [31:0]           wword,
    output logic [31:0]           rdata
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic                  misaligned
`endif
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rword >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

        be    = '1;
        wword = wdata;
        rdata = rword;
        unique case (size)
            SZ_B: begin
                be    = 4'(1) << addr_lo;
                wword = {4{wdata[7:0]}};
                rdata = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            default: begin
                be    = '1;
                wword = wdata;
                rdata = rword;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        unique case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_lo[0];
            default: misaligned = (addr_lo != '0);
        endcase
    end
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, one-cycle ready pulse.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          enter_resp;
  logic          wr_en;
  logic [AW+1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [1:0]    sel_size;
  logic          sel_uns;
  logic          sel_we;
  logic [AW-1:0] sel_idx;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   ld_data;
  logic          mis;

  assign req = bus.R_en | bus.W_en;

  // With LATENCY=0 the commit edge is the accept edge, so operands come straight from the bus.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_addr  = bus.ram_addr[AW+1:0];
      sel_wdata = bus.Wr_mem_data;
      sel_size  = bus.mem_size;
      sel_uns   = bus.mem_unsigned;
      sel_we    = bus.W_en;
    end else begin
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
      sel_size  = size_q;
      sel_uns   = uns_q;
      sel_we    = we_q;
    end
  end

  assign sel_idx = sel_addr[AW+1:2];

  dmem_lane_align u_align (
    .size        (sel_size),
    .addr_lo     (sel_addr[1:0]),
    .wdata       (sel_wdata),
    .rword       (mem_q[sel_idx]),
    .is_unsigned (sel_uns),
    .be          (be),
    .wword       (wword),
    .rdata       (ld_data)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misaligned  (mis)
`endif
  );

`ifndef DMEM_MISALIGN_TRAP_EN
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = bus.ram_addr[AW+1:0];
          wdata_d = bus.Wr_mem_data;
          size_d  = bus.mem_size;
          uns_d   = bus.mem_unsigned;
          we_d    = bus.W_en;
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT4) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && !sel_we) begin
      rdata_d = mis ? '0 : ld_data;
    end
  end

  assign wr_en = enter_resp & sel_we & ~mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (wr_en && be[i]) begin
        mem_q[sel_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.Rd_mem_data = rdata_q;
  assign bus.mem_ready   = (state_q == S_RESP);
  assign bus.mem_busy    = (state_q != S_IDLE);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign bus.mem_err     = (state_q == S_RESP) & mis;
`endif

endmodule
